tcp_rt_timer_sched: RTL and testbench
=====================================

Name: tcp_rt_timer_sched

Overview:
Per-flow retransmit-timer scheduler for the TCP engine. It holds one armed/timestamp timer entry per flow and a free-running cycle counter. A scan pointer visits flows round-robin, and the block issues one expire request per timed-out flow over a valid/ready handshake to the retransmit path. The TX path arms timers; the RX ACK path disarms them.

Parameters:
NUM_FLOWS, MAX_TCP_FLOWS (8), number of timer entries; power of two.
FLOWID_W, FLOWID_W (3), flow id width, equal to log2(NUM_FLOWS).
TIMESTAMP_W, TIMESTAMP_W (64), width of the cycle counter and stored timestamps.
TIMEOUT_CYCLES, RT_TIMEOUT_CYCLES (250000000), elapsed cycles at which an armed timer expires.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
arm_req_val  in  1  arm or re-arm request
arm_req_flowid  in  FLOWID_W  flow to arm
arm_req_rdy  out  1  arm accepted when val&rdy
disarm_req_val  in  1  disarm request
disarm_req_flowid  in  FLOWID_W  flow to disarm
disarm_req_rdy  out  1  disarm accepted when val&rdy
expire_val  out  1  a timed-out flow is presented
expire_flowid  out  FLOWID_W  timed-out flow id
expire_rdy  in  1  consumer accepts the expire
curr_time  out  TIMESTAMP_W  free-running cycle counter

Behaviour:
- Reset:
  - curr_time=0; all entries timer_armed=0, timestamp=0.
  - scan_ptr=0; state=SCAN.
  - expire_val=0, expire_flowid=0.
  - arm_req_rdy=0, disarm_req_rdy=0. Both rdy go to 1 from the first cycle after rst deasserts and stay 1, so they are never backpressured.
- curr_time increments by 1 every non-reset cycle and wraps modulo 2^TIMESTAMP_W.
- Arm accepted for flow F in cycle t: entry[F] becomes armed=1, timestamp=curr_time(t), visible from t+1. Re-arming an armed flow overwrites its timestamp.
- Disarm accepted for F: entry[F].armed=0 from t+1. Disarming an already disarmed flow is a no-op.
- Arm and disarm to the same F in the same cycle: arm wins. To different flows: both take effect.
- Expiry test: armed && (curr_time - timestamp) >= TIMEOUT_CYCLES. The subtraction is unsigned modulo 2^TIMESTAMP_W, so it is wrap-safe.
- State SCAN:
  - Each cycle, evaluate entry[scan_ptr] using table contents as of that cycle, excluding same-cycle writes.
  - If it has expired: latch expire_flowid=scan_ptr, go to EXPIRE_OUT, and drive expire_val=1 from the next cycle.
  - Otherwise: scan_ptr = scan_ptr+1, wrapping NUM_FLOWS-1 to 0.
- State EXPIRE_OUT:
  - expire_val=1 and expire_flowid stay stable until the handshake completes; the scan is frozen.
  - On expire_val&&expire_rdy: entry[expire_flowid].armed=0, unless an arm for that flow is accepted the same cycle, in which case arm wins. Then expire_val=0 next cycle, scan_ptr advances by 1, and state returns to SCAN.
  - If an arm or disarm for expire_flowid is accepted while expire_rdy=0: the pending expire is cancelled. expire_val=0 next cycle, scan_ptr advances, state returns to SCAN, and the entry takes the arm/disarm result.
  - Arms and disarms to other flows apply normally in this state.
- At most one expire per flow per arming.
- Latency from arm at t to expire_val: at least t+TIMEOUT_CYCLES+1, at most t+TIMEOUT_CYCLES+NUM_FLOWS+1 when expire_rdy is held 1 and no other flow expires.
- rst asserted mid-handshake: everything returns to reset values next cycle. The pending expire is lost and all timers are disarmed.
- Flow ids are always in range because NUM_FLOWS=2^FLOWID_W.

Decomposition:
- Shared tcp_pkg already holds tx_ack_timer_struct, TIMESTAMP_W, MAX_TCP_FLOWS, FLOWID_W and RT_TIMEOUT_CYCLES; reuse them.
- Add an rt_sched_state_e enum {SCAN, EXPIRE_OUT} to tcp_pkg.
- One sub-module, tcp_rt_timer_table: an array of tx_ack_timer_struct with an arm write port, a disarm port, an expire-clear port applying the priority rules, and a combinational read port at scan_ptr.
- The FSM, scan pointer and counter stay in tcp_rt_timer_sched.

Test Plan:
(Bench overrides TIMEOUT_CYCLES=100.)
- Reset, then idle for 1000 cycles -> expire_val stays 0; rdy outputs are 0 during rst and 1 afterwards; curr_time=1000.
- Arm flow 3 at t, expire_rdy=1 -> exactly one expire with flowid=3, expire_val rising in [t+101, t+109]; no further expire for 500 cycles.
- Arm flow 2 at t, disarm flow 2 at t+50 -> no expire. Separately, arm flow 4 at t and re-arm at t+90 -> expire flowid=4 in [t+191, t+199].
- Arm flow 1 at t and flow 5 at t+1, expire_rdy=0 until t+300 -> expire_val is held with a stable flowid and the scan frozen; after release, both flows expire, one per handshake, in scan order.
- During EXPIRE_OUT for flow 6 with expire_rdy=0, arm flow 6 -> expire_val drops next cycle; flow 6 expires again about 100 cycles after the re-arm. Repeat with a disarm -> no expire at all.
- TIMESTAMP_W=8, arm flow 0 at curr_time=200 -> expire detected after the counter wraps, within [t+101, t+109].

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared TCP engine types and constants.
// Also holds the state encoding for the retransmit-timer scheduler.
package tcp_pkg;

    localparam int MAX_TCP_FLOWS = 8;
    localparam int FLOWID_W = $clog2(MAX_TCP_FLOWS);
    localparam int TIMESTAMP_W = 64;
    localparam longint unsigned RT_TIMEOUT_CYCLES = 64'd250000000;

    typedef struct packed {
        logic                   timer_armed;
        logic [TIMESTAMP_W-1:0] timestamp;
    } tx_ack_timer_struct;

    typedef enum logic {
        SCAN       = 1'b0,
        EXPIRE_OUT = 1'b1
    } rt_sched_state_e;

endpackage

// File: rtl/tcp_rt_timer_table.sv
// Per-flow retransmit timer storage.
// Supports arm, disarm and expire-clear writes, plus one combinational read port.
module tcp_rt_timer_table #(
    parameter int NUM_FLOWS   = tcp_pkg::MAX_TCP_FLOWS,
    parameter int FLOWID_W    = tcp_pkg::FLOWID_W,
    parameter int TIMESTAMP_W = tcp_pkg::TIMESTAMP_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm_en,
    input  logic [FLOWID_W-1:0]    arm_flowid,
    input  logic [TIMESTAMP_W-1:0] arm_time,
    input  logic                   disarm_en,
    input  logic [FLOWID_W-1:0]    disarm_flowid,
    input  logic                   clear_en,
    input  logic [FLOWID_W-1:0]    clear_flowid,
    input  logic [FLOWID_W-1:0]    rd_flowid,
    output logic                   rd_armed,
    output logic [TIMESTAMP_W-1:0] rd_timestamp
);
    import tcp_pkg::*;

    localparam int STORE_W = tcp_pkg::TIMESTAMP_W;

    tx_ack_timer_struct entries [NUM_FLOWS];
    logic [STORE_W-1:0] arm_time_ext;

    // Narrower timestamps are zero-extended into the shared entry format.
    assign arm_time_ext = STORE_W'(arm_time);

    // An arm to a flow overrides a disarm or expire-clear for the same flow in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (arm_en && arm_flowid == FLOWID_W'(i)) begin
                    entries[i].timer_armed <= 1'b1;
                    entries[i].timestamp   <= arm_time_ext;
                end else if ((disarm_en && disarm_flowid == FLOWID_W'(i)) ||
                             (clear_en && clear_flowid == FLOWID_W'(i))) begin
                    entries[i].timer_armed <= 1'b0;
                end
            end
        end
    end

    assign rd_armed     = entries[rd_flowid].timer_armed;
    assign rd_timestamp = entries[rd_flowid].timestamp[TIMESTAMP_W-1:0];

endmodule

// File: rtl/tcp_rt_timer_sched.sv
// Round-robin retransmit-timer scheduler.
// Scans the per-flow timers and hands each timed-out flow to the retransmit path once per arming.
module tcp_rt_timer_sched #(
    parameter int              NUM_FLOWS      = tcp_pkg::MAX_TCP_FLOWS,
    parameter int              FLOWID_W       = tcp_pkg::FLOWID_W,
    parameter int              TIMESTAMP_W    = tcp_pkg::TIMESTAMP_W,
    parameter longint unsigned TIMEOUT_CYCLES = tcp_pkg::RT_TIMEOUT_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arm_req_val,
    input  logic [FLOWID_W-1:0]    arm_req_flowid,
    output logic                   arm_req_rdy,
    input  logic                   disarm_req_val,
    input  logic [FLOWID_W-1:0]    disarm_req_flowid,
    output logic                   disarm_req_rdy,
    output logic                   expire_val,
    output logic [FLOWID_W-1:0]    expire_flowid,
    input  logic                   expire_rdy,
    output logic [TIMESTAMP_W-1:0] curr_time
);
    import tcp_pkg::*;

    rt_sched_state_e        state, state_next;
    logic [FLOWID_W-1:0]    scan_ptr, scan_ptr_next;
    logic [FLOWID_W-1:0]    exp_id, exp_id_next;
    logic                   req_rdy;
    logic                   arm_fire, disarm_fire, clear_en;
    logic                   rd_armed, scan_expired, pending_touched;
    logic [TIMESTAMP_W-1:0] rd_timestamp, elapsed;

    assign arm_req_rdy    = req_rdy;
    assign disarm_req_rdy = req_rdy;
    assign arm_fire       = arm_req_val && req_rdy;
    assign disarm_fire    = disarm_req_val && req_rdy;
    assign expire_val     = (state == EXPIRE_OUT);
    assign expire_flowid  = exp_id;

    // Modular subtraction keeps the age correct across counter wrap.
    assign elapsed      = curr_time - rd_timestamp;
    assign scan_expired = rd_armed && (elapsed >= TIMESTAMP_W'(TIMEOUT_CYCLES));

    assign pending_touched = (arm_fire && arm_req_flowid == exp_id) ||
                             (disarm_fire && disarm_req_flowid == exp_id);

    tcp_rt_timer_table #(
        .NUM_FLOWS   (NUM_FLOWS),
        .FLOWID_W    (FLOWID_W),
        .TIMESTAMP_W (TIMESTAMP_W)
    ) u_table (
        .clk           (clk),
        .rst           (rst),
        .arm_en        (arm_fire),
        .arm_flowid    (arm_req_flowid),
        .arm_time      (curr_time),
        .disarm_en     (disarm_fire),
        .disarm_flowid (disarm_req_flowid),
        .clear_en      (clear_en),
        .clear_flowid  (exp_id),
        .rd_flowid     (scan_ptr),
        .rd_armed      (rd_armed),
        .rd_timestamp  (rd_timestamp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            scan_ptr  <= '0;
            exp_id    <= '0;
            curr_time <= '0;
            req_rdy   <= 1'b0;
        end else begin
            state     <= state_next;
            scan_ptr  <= scan_ptr_next;
            exp_id    <= exp_id_next;
            curr_time <= curr_time + TIMESTAMP_W'(1);
            req_rdy   <= 1'b1;
        end
    end

    // The scan pointer stays frozen while an expire is outstanding.
    always_comb begin
        state_next    = state;
        scan_ptr_next = scan_ptr;
        exp_id_next   = exp_id;
        clear_en      = 1'b0;
        case (state)
            SCAN: begin
                if (scan_expired) begin
                    exp_id_next = scan_ptr;
                    state_next  = EXPIRE_OUT;
                end else begin
                    scan_ptr_next = scan_ptr + FLOWID_W'(1);
                end
            end
            EXPIRE_OUT: begin
                if (expire_rdy) begin
                    clear_en      = 1'b1;
                    state_next    = SCAN;
                    scan_ptr_next = scan_ptr + FLOWID_W'(1);
                end else if (pending_touched) begin
                    state_next    = SCAN;
                    scan_ptr_next = scan_ptr + FLOWID_W'(1);
                end
            end
            default: state_next = SCAN;
        endcase
    end

endmodule

// File: tb/tb_tcp_rt_timer_sched.sv
// Directed testbench for tcp_rt_timer_sched with a short timeout.
// A second instance uses an 8-bit counter to exercise timestamp wrap.
module tb_tcp_rt_timer_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arm_req_val = 1'b0;
    logic [2:0]  arm_req_flowid = '0;
    logic        arm_req_rdy;
    logic        disarm_req_val = 1'b0;
    logic [2:0]  disarm_req_flowid = '0;
    logic        disarm_req_rdy;
    logic        expire_val;
    logic [2:0]  expire_flowid;
    logic        expire_rdy = 1'b1;
    logic [63:0] curr_time;

    logic        w_arm_val = 1'b0;
    logic [2:0]  w_arm_flowid = '0;
    logic        w_arm_rdy;
    logic        w_disarm_val = 1'b0;
    logic [2:0]  w_disarm_flowid = '0;
    logic        w_disarm_rdy;
    logic        w_expire_val;
    logic [2:0]  w_expire_flowid;
    logic        w_expire_rdy = 1'b1;
    logic [7:0]  w_curr_time;

    longint unsigned cyc;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    tcp_rt_timer_sched #(
        .NUM_FLOWS(8), .FLOWID_W(3), .TIMESTAMP_W(64), .TIMEOUT_CYCLES(64'd100)
    ) dut (
        .clk(clk), .rst(rst),
        .arm_req_val(arm_req_val), .arm_req_flowid(arm_req_flowid), .arm_req_rdy(arm_req_rdy),
        .disarm_req_val(disarm_req_val), .disarm_req_flowid(disarm_req_flowid),
        .disarm_req_rdy(disarm_req_rdy),
        .expire_val(expire_val), .expire_flowid(expire_flowid), .expire_rdy(expire_rdy),
        .curr_time(curr_time)
    );

    tcp_rt_timer_sched #(
        .NUM_FLOWS(8), .FLOWID_W(3), .TIMESTAMP_W(8), .TIMEOUT_CYCLES(64'd100)
    ) dut_w (
        .clk(clk), .rst(rst),
        .arm_req_val(w_arm_val), .arm_req_flowid(w_arm_flowid), .arm_req_rdy(w_arm_rdy),
        .disarm_req_val(w_disarm_val), .disarm_req_flowid(w_disarm_flowid),
        .disarm_req_rdy(w_disarm_rdy),
        .expire_val(w_expire_val), .expire_flowid(w_expire_flowid), .expire_rdy(w_expire_rdy),
        .curr_time(w_curr_time)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkRange(input string tag, input logic [63:0] obs,
                              input logic [63:0] lo, input logic [63:0] hi);
        compared++;
        assert (obs >= lo && obs <= hi) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected range [%0d,%0d]", tag, obs, lo, hi);
        end
    endtask

    // Drives one cycle of arm/disarm requests; t is the cycle in which they are accepted.
    task automatic applyStimulus(input logic a, input logic [2:0] af, input logic d,
                                 input logic [2:0] df, output longint unsigned t);
        arm_req_val       = a;
        arm_req_flowid    = af;
        disarm_req_val    = d;
        disarm_req_flowid = df;
        t = cyc;
        tick();
        arm_req_val    = 1'b0;
        disarm_req_val = 1'b0;
    endtask

    task automatic waitExpire(input int maxc, output logic seen,
                              output longint unsigned at, output logic [2:0] fid);
        seen = 1'b0;
        at   = 0;
        fid  = '0;
        for (int i = 0; i < maxc; i++) begin
            if (expire_val === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                fid  = expire_flowid;
                break;
            end
            tick();
        end
    endtask

    task automatic watchNone(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (expire_val !== 1'b0) hits++;
        end
    endtask

    initial begin
        longint unsigned t, u, at, at2;
        logic seen;
        logic [2:0] fid, first_fid;
        int hits, bad;

        // Reset and idle
        tick(); tick(); tick();
        checkOutput("rst_arm_rdy", arm_req_rdy, 0);
        checkOutput("rst_disarm_rdy", disarm_req_rdy, 0);
        checkOutput("rst_expire_val", expire_val, 0);
        checkOutput("rst_expire_flowid", expire_flowid, 0);
        checkOutput("rst_curr_time", curr_time, 0);
        rst = 1'b0;
        tick();
        checkOutput("arm_rdy_after_rst", arm_req_rdy, 1);
        checkOutput("disarm_rdy_after_rst", disarm_req_rdy, 1);
        watchNone(999, hits);
        checkOutput("idle_no_expire", hits, 0);
        checkOutput("idle_curr_time", curr_time, 1000);
        checkOutput("idle_rdy_held", arm_req_rdy & disarm_req_rdy, 1);

        // Single expire for flow 3
        applyStimulus(1'b1, 3'd3, 1'b0, 3'd0, t);
        waitExpire(200, seen, at, fid);
        checkOutput("f3_seen", seen, 1);
        checkOutput("f3_flowid", fid, 3);
        checkRange("f3_latency", at, t + 101, t + 109);
        watchNone(500, hits);
        checkOutput("f3_only_once", hits, 0);

        // Disarm before timeout
        applyStimulus(1'b1, 3'd2, 1'b0, 3'd0, t);
        repeat (49) tick();
        applyStimulus(1'b0, 3'd0, 1'b1, 3'd2, u);
        checkOutput("f2_disarm_cycle", u, t + 50);
        watchNone(300, hits);
        checkOutput("f2_no_expire", hits, 0);

        // Re-arm restarts the timer
        applyStimulus(1'b1, 3'd4, 1'b0, 3'd0, t);
        repeat (89) tick();
        applyStimulus(1'b1, 3'd4, 1'b0, 3'd0, u);
        waitExpire(250, seen, at, fid);
        checkOutput("f4_seen", seen, 1);
        checkOutput("f4_flowid", fid, 4);
        checkRange("f4_latency", at, t + 191, t + 199);
        watchNone(200, hits);
        checkOutput("f4_only_once", hits, 0);

        // Arm and disarm of the same flow in one cycle: arm wins
        applyStimulus(1'b1, 3'd7, 1'b1, 3'd7, t);
        waitExpire(200, seen, at, fid);
        checkOutput("f7_arm_wins_seen", seen, 1);
        checkOutput("f7_flowid", fid, 7);
        checkRange("f7_latency", at, t + 101, t + 109);
        watchNone(100, hits);
        checkOutput("f7_only_once", hits, 0);

        // Backpressure holds the expire and freezes the scan
        expire_rdy = 1'b0;
        applyStimulus(1'b1, 3'd1, 1'b0, 3'd0, t);
        applyStimulus(1'b1, 3'd5, 1'b0, 3'd0, u);
        waitExpire(200, seen, at, first_fid);
        checkOutput("bp_first_seen", seen, 1);
        checkOutput("bp_first_is_1_or_5", (first_fid == 3'd1 || first_fid == 3'd5), 1);
        checkRange("bp_first_latency", at, t + 101, t + 110);
        bad = 0;
        while (cyc < t + 300) begin
            tick();
            if (expire_val !== 1'b1 || expire_flowid !== first_fid) bad++;
        end
        checkOutput("bp_held_stable", bad, 0);
        expire_rdy = 1'b1;
        tick();
        checkOutput("bp_val_drop", expire_val, 0);
        waitExpire(20, seen, at, fid);
        checkOutput("bp_second_seen", seen, 1);
        checkOutput("bp_second_flowid", fid, (first_fid == 3'd1) ? 3'd5 : 3'd1);
        checkOutput("bp_second_cycle", at, t + 305);
        watchNone(200, hits);
        checkOutput("bp_no_more", hits, 0);

        // Re-arm cancels a pending expire
        expire_rdy = 1'b0;
        applyStimulus(1'b1, 3'd6, 1'b0, 3'd0, t);
        waitExpire(200, seen, at, fid);
        checkOutput("f6_seen", seen, 1);
        checkOutput("f6_flowid", fid, 6);
        repeat (5) tick();
        checkOutput("f6_held", expire_val, 1);
        applyStimulus(1'b1, 3'd6, 1'b0, 3'd0, u);
        checkOutput("f6_rearm_cancel", expire_val, 0);
        expire_rdy = 1'b1;
        waitExpire(200, seen, at2, fid);
        checkOutput("f6_again_seen", seen, 1);
        checkOutput("f6_again_flowid", fid, 6);
        checkRange("f6_again_latency", at2, u + 101, u + 109);
        watchNone(150, hits);
        checkOutput("f6_again_once", hits, 0);

        // Disarm cancels a pending expire
        expire_rdy = 1'b0;
        applyStimulus(1'b1, 3'd6, 1'b0, 3'd0, t);
        waitExpire(200, seen, at, fid);
        checkOutput("f6d_seen", seen, 1);
        repeat (5) tick();
        applyStimulus(1'b0, 3'd0, 1'b1, 3'd6, u);
        checkOutput("f6d_disarm_cancel", expire_val, 0);
        expire_rdy = 1'b1;
        watchNone(300, hits);
        checkOutput("f6d_no_expire", hits, 0);

        // Narrow counter wraps between arm and expiry
        for (int i = 0; i < 300 && cyc[7:0] != 8'd200; i++) tick();
        checkOutput("w_curr_time", w_curr_time, cyc[7:0]);
        checkOutput("w_arm_rdy", w_arm_rdy, 1);
        w_arm_val    = 1'b1;
        w_arm_flowid = 3'd0;
        t = cyc;
        tick();
        w_arm_val = 1'b0;
        seen = 1'b0;
        at   = 0;
        fid  = '0;
        for (int i = 0; i < 200; i++) begin
            if (w_expire_val === 1'b1) begin
                seen = 1'b1;
                at   = cyc;
                fid  = w_expire_flowid;
                break;
            end
            tick();
        end
        checkOutput("w_seen", seen, 1);
        checkOutput("w_flowid", fid, 0);
        checkRange("w_latency", at, t + 101, t + 109);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
